// File: rtl/spectro_pkg.sv
// Shared constants and readout FSM state type for the spectrogram
// ping-pong memory read side.
package spectro_pkg;

    localparam int SPEC_DEPTH  = 200;
    localparam int SPEC_DATA_W = 3;
    localparam int SPEC_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/spectro_readout.sv
// Read-side controller for the two-bank spectrogram memory: scans a full bank
// through the memory read port and streams each magnitude on valid/ready.
module spectro_readout
    import spectro_pkg::*;
#(
    parameter int DEPTH  = SPEC_DEPTH,
    parameter int DATA_W = SPEC_DATA_W,
    parameter int ADDR_W = SPEC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank_ready,
    input  logic              bank_ready_sel,
    input  logic              overrun_clr,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address_out,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    localparam int               IDX_W    = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    rd_state_t         state_reg;
    logic [1:0]        pend_reg;
    logic [1:0]        pend_next;
    logic [1:0]        pend_set;
    logic [1:0]        pend_clr;
    logic [IDX_W-1:0]  idx_reg;
    logic              cur_bank_reg;
    logic              last_bank_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_last_reg;
    logic              frame_done_reg;
    logic              overrun_reg;
    logic              overrun_next;
    logic              start;
    logic              pick_bank;
    logic              violation;
    logic              idx_is_last;

    // Both pending: alternate away from the bank served last.
    always_comb begin
        start       = (state_reg == IDLE) && (pend_reg != 2'b00);
        pick_bank   = (pend_reg == 2'b11) ? ~last_bank_reg : pend_reg[1];
        idx_is_last = (idx_reg == LAST_IDX);
        violation   = bank_ready &&
                      (pend_reg[bank_ready_sel] ||
                       ((state_reg != IDLE) && (cur_bank_reg == bank_ready_sel)));
        overrun_next = overrun_reg;
        if (violation) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end
    end

    // A new declaration beats the clear issued when the bank is picked up.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            assign pend_set[gi]  = bank_ready && (bank_ready_sel == 1'(gi));
            assign pend_clr[gi]  = start && (pick_bank == 1'(gi));
            assign pend_next[gi] = pend_set[gi] | (pend_reg[gi] & ~pend_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pend_reg       <= 2'b00;
            idx_reg        <= '0;
            cur_bank_reg   <= 1'b0;
            last_bank_reg  <= 1'b1;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            pend_reg       <= pend_next;
            overrun_reg    <= overrun_next;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cur_bank_reg <= pick_bank;
                        idx_reg      <= '0;
                        state_reg    <= READ;
                    end
                end
                READ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    out_data_reg <= mem_data_out;
                    out_last_reg <= idx_is_last;
                    state_reg    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx_is_last) begin
                            frame_done_reg <= 1'b1;
                            last_bank_reg  <= cur_bank_reg;
                            state_reg      <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= READ;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy            = (state_reg != IDLE);
    assign mem_read_enable = (state_reg == READ);
    assign mem_address_out = mem_read_enable ? {cur_bank_reg, idx_reg} : '0;
    assign out_valid       = (state_reg == OUT);
    assign out_data        = out_data_reg;
    assign out_last        = out_last_reg;
    assign frame_done      = frame_done_reg;
    assign overrun         = overrun_reg;

endmodule

// File: tb/tb_spectro_readout.sv
// Directed bench for spectro_readout with a frame-level reference model that
// checks the stream, memory reads and bookkeeping outputs on every cycle.
module tb_spectro_readout;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bank_ready = 1'b0;
    logic       bank_ready_sel = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic       mem_read_enable;
    logic [8:0] mem_address_out;
    logic [2:0] mem_data_out;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       busy;
    logic       overrun;

    spectro_readout dut (
        .clk             (clk),
        .reset           (reset),
        .bank_ready      (bank_ready),
        .bank_ready_sel  (bank_ready_sel),
        .overrun_clr     (overrun_clr),
        .mem_read_enable (mem_read_enable),
        .mem_address_out (mem_address_out),
        .mem_data_out    (mem_data_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .frame_done      (frame_done),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // Memory contents: bank 0 holds (i mod 8), bank 1 a different pattern.
    logic [2:0] bmem [512];
    always @(posedge clk) begin
        if (mem_read_enable) mem_data_out <= bmem[mem_address_out];
    end

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model state
    bit [1:0]   m_pend = 2'b00;
    bit         m_last_bank = 1'b1;
    bit         m_active = 1'b0;
    bit         m_bank = 1'b0;
    int         m_idx = 0;
    bit         m_overrun = 1'b0;
    bit         m_fd_due = 1'b0;
    int         m_rd_due = -10;
    int         m_frame_samples = 0;
    int         last_frame_samples = 0;
    int         m_last_data = 0;
    int         frames_done = 0;
    bit         prev_stall = 1'b0;
    logic [2:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin : compare
        bit         exp_valid;
        bit         was_active;
        bit         viol;
        bit         b;
        bit [1:0]   old_pend;
        logic [8:0] exp_addr;
        if (checking) begin
            cyc++;
            exp_addr  = {m_bank, 8'(m_idx)};
            exp_valid = m_active && (cyc >= m_rd_due + 2);
            chk("busy", busy, m_active);
            chk("frame_done", frame_done, m_fd_due);
            m_fd_due = 1'b0;
            chk("overrun", overrun, m_overrun);
            chk("rd_en", mem_read_enable, cyc == m_rd_due);
            chk("addr", mem_address_out, mem_read_enable ? exp_addr : 9'd0);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("out_data", out_data, bmem[exp_addr]);
                chk("out_last", out_last, m_idx == DEPTH - 1);
            end
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            was_active = m_active;
            old_pend   = m_pend;
            if (!m_active && m_pend != 2'b00) begin
                b = (m_pend == 2'b11) ? !m_last_bank : m_pend[1];
                m_pend[b] = 1'b0;
                m_bank = b;
                m_idx = 0;
                m_active = 1'b1;
                m_rd_due = cyc + 1;
                m_frame_samples = 0;
            end else if (exp_valid && out_ready) begin
                m_frame_samples++;
                if (m_idx == DEPTH - 1) begin
                    m_active = 1'b0;
                    m_fd_due = 1'b1;
                    m_last_bank = m_bank;
                    m_last_data = int'(out_data);
                    last_frame_samples = m_frame_samples;
                    frames_done++;
                    $display("frame %0d: bank %0d, %0d samples", frames_done, m_bank, m_frame_samples);
                end else begin
                    m_idx++;
                    m_rd_due = cyc + 1;
                end
            end
            viol = 1'b0;
            if (bank_ready) begin
                viol = old_pend[bank_ready_sel] || (was_active && m_bank == bank_ready_sel);
                m_pend[bank_ready_sel] = 1'b1;
            end
            if (viol) m_overrun = 1'b1;
            else if (overrun_clr) m_overrun = 1'b0;
            if (reset) begin
                m_pend = 2'b00;
                m_last_bank = 1'b1;
                m_active = 1'b0;
                m_bank = 1'b0;
                m_idx = 0;
                m_overrun = 1'b0;
                m_fd_due = 1'b0;
                m_rd_due = -10;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit b);
        bank_ready = 1'b1;
        bank_ready_sel = b;
        tick();
        bank_ready = 1'b0;
    endtask

    task automatic wait_fd(input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (frame_done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_fd_seen"}, seen, 1);
    endtask

    task automatic wait_idx(input int n, input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (out_valid === 1'b1 && m_idx == n) seen = 1'b1;
            else tick();
        end
        chk({tag, "_idx_seen"}, seen, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit done;
        bit stalled;
        for (int i = 0; i < 512; i++) begin
            bmem[i] = (i < 256) ? 3'(i % 8) : 3'((i * 5 + 3) % 8);
        end
        repeat (3) tick();
        checking = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_read_enable, 0);
        chk("rst_addr", mem_address_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // Single frame, latency and contents
        out_ready = 1'b1;
        pulse(1'b0);
        chk("t1_idle", busy, 0);
        tick();
        chk("t1_rd_en", mem_read_enable, 1);
        chk("t1_addr0", mem_address_out, 0);
        tick();
        chk("t1_valid_t3", out_valid, 0);
        tick();
        chk("t1_valid_t4", out_valid, 1);
        chk("t1_data0", out_data, 0);
        wait_fd(1000, "t1");
        chk("t1_samples", last_frame_samples, 200);
        chk("t1_last_data", m_last_data, 7);
        repeat (3) tick();

        // Ping-pong: bank 1 declared mid-frame
        pulse(1'b0);
        repeat (100) tick();
        pulse(1'b1);
        wait_fd(1000, "t2a");
        chk("t2_one_idle", busy, 0);
        tick();
        chk("t2_rd_en", mem_read_enable, 1);
        chk("t2_addr256", mem_address_out, 256);
        wait_fd(1000, "t2b");
        chk("t2_samples", last_frame_samples, 200);
        chk("t2_last_data", m_last_data, 6);
        chk("t2_overrun", overrun, 0);
        repeat (3) tick();

        // Backpressure: random ready, 10-cycle stall at sample 50
        pulse(1'b0);
        done = 1'b0;
        stalled = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            if (!stalled && out_valid === 1'b1 && m_idx == 50) begin
                out_ready = 1'b0;
                repeat (10) tick();
                stalled = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                if (frame_done === 1'b1) done = 1'b1;
            end
        end
        chk("t3_fd_seen", done, 1);
        chk("t3_samples", last_frame_samples, 200);
        out_ready = 1'b1;
        repeat (3) tick();

        // Overrun: bank 0 declared twice before its frame starts
        bank_ready = 1'b1;
        bank_ready_sel = 1'b0;
        tick();
        tick();
        bank_ready = 1'b0;
        chk("t4_ov_set", overrun, 1);
        wait_fd(1000, "t4a");
        chk("t4_ov_sticky", overrun, 1);
        tick();
        chk("t4_reread_en", mem_read_enable, 1);
        chk("t4_reread_addr", mem_address_out, 0);
        wait_fd(1000, "t4b");
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_ov_clr", overrun, 0);
        pulse(1'b0);
        repeat (60) tick();
        bank_ready = 1'b1;
        bank_ready_sel = 1'b0;
        overrun_clr = 1'b1;
        tick();
        bank_ready = 1'b0;
        overrun_clr = 1'b0;
        chk("t4_set_beats_clr", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_ov_clr2", overrun, 0);
        wait_fd(1000, "t4c");
        wait_fd(1000, "t4d");
        chk("t4_samples", last_frame_samples, 200);
        repeat (3) tick();

        // Arbitration: both banks pending when the frame ends
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse(1'b0);
        repeat (30) tick();
        pulse(1'b1);
        tick();
        pulse(1'b0);
        wait_fd(1000, "t5a");
        tick();
        chk("t5_first_bank1", mem_address_out, 256);
        wait_fd(1000, "t5b");
        tick();
        chk("t5_then_bank0", mem_address_out, 0);
        wait_fd(1000, "t5c");
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        repeat (3) tick();

        // Reset mid-frame at sample 77
        pulse(1'b0);
        wait_idx(77, 1000, "t6");
        reset = 1'b1;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_last", out_last, 0);
        chk("t6_rd_en", mem_read_enable, 0);
        chk("t6_addr", mem_address_out, 0);
        chk("t6_fd", frame_done, 0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_no_fd", frame_done, 0);
        end
        pulse(1'b0);
        tick();
        chk("t6_restart_en", mem_read_enable, 1);
        chk("t6_restart_addr", mem_address_out, 0);
        wait_fd(1000, "t6");
        chk("t6_samples", last_frame_samples, 200);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
